// File: rtl/fir_pkg.sv
// Shared FIR definitions: default geometry, coefficient saturation constants
// and the coefficient-loader state encoding.
package fir_pkg;

    localparam int FIR_TAPS        = 128;
    localparam int FIR_COEFF_WIDTH = 16;
    localparam int FIR_ADDR_WIDTH  = 7;

    // Most negative coefficient and the value it is clamped to, so that the
    // stored table is symmetric around zero.
    localparam logic [FIR_COEFF_WIDTH-1:0] COEFF_MIN = 16'h8000;
    localparam logic [FIR_COEFF_WIDTH-1:0] COEFF_SAT = 16'h8001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        MIRROR = 2'd2,
        DONE   = 2'd3
    } loader_state_e;

endpackage

// File: rtl/coeff_loader.sv
// coeff_loader: write-side sequencer for the FIR coefficient RAM.
// Accepts a start-framed burst of coefficients on a valid/ready stream and
// writes them to consecutive RAM addresses, one cycle after acceptance.
// Build option COEFF_LOADER_SYMMETRIC_EN: linear-phase load, only TAPS/2
// beats are taken and each beat is also written to its mirror address
// TAPS-1-k in a dedicated MIRROR cycle.
module coeff_loader
    import fir_pkg::*;
#(
    parameter int TAPS        = FIR_TAPS,
    parameter int COEFF_WIDTH = FIR_COEFF_WIDTH,
    parameter int ADDR_WIDTH  = FIR_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [COEFF_WIDTH-1:0] s_data,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [COEFF_WIDTH-1:0] wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   sat_flag,
    output logic                   abort_flag
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX_C  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_IDX_C   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR_C  = ADDR_WIDTH'(TAPS - 1);
`ifdef COEFF_LOADER_SYMMETRIC_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX_C  = ADDR_WIDTH'(TAPS / 2 - 1);
`else
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX_C  = ADDR_WIDTH'(TAPS - 1);
`endif
    localparam logic [COEFF_WIDTH-1:0] MIN_C = {1'b1, {(COEFF_WIDTH-1){1'b0}}};
    localparam logic [COEFF_WIDTH-1:0] SAT_C = {1'b1, {(COEFF_WIDTH-2){1'b0}}, 1'b1};

    loader_state_e           state_r;
    loader_state_e           state_nxt_s;
    logic [ADDR_WIDTH-1:0]   index_r;
    logic [ADDR_WIDTH-1:0]   index_nxt_s;

    logic                    s_ready_r,    s_ready_nxt_s;
    logic                    wr_en_r,      wr_en_nxt_s;
    logic [ADDR_WIDTH-1:0]   wr_addr_r,    wr_addr_nxt_s;
    logic [COEFF_WIDTH-1:0]  wr_data_r,    wr_data_nxt_s;
    logic                    busy_r,       busy_nxt_s;
    logic                    done_r,       done_nxt_s;
    logic                    sat_flag_r,   sat_flag_nxt_s;
    logic                    abort_flag_r, abort_flag_nxt_s;

    logic                    accept_s;
    logic                    is_min_s;
    logic [COEFF_WIDTH-1:0]  data_sat_s;

    // s_ready_r is high exactly while in LOAD, so it doubles as the accept qualifier.
    assign accept_s   = s_valid && s_ready_r;
    assign is_min_s   = (s_data == MIN_C);
    assign data_sat_s = is_min_s ? SAT_C : s_data;

    // State and beat-index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            index_r <= ZERO_IDX_C;
        end else begin
            state_r <= state_nxt_s;
            index_r <= index_nxt_s;
        end
    end

    // Next-state and index sequencing; abort always returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        index_nxt_s = index_r;
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt_s = LOAD;
                    index_nxt_s = ZERO_IDX_C;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (accept_s) begin
`ifdef COEFF_LOADER_SYMMETRIC_EN
                    state_nxt_s = MIRROR;
`else
                    if (index_r == LAST_IDX_C) begin
                        state_nxt_s = DONE;
                    end else begin
                        index_nxt_s = index_r + ONE_IDX_C;
                    end
`endif
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            MIRROR: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (index_r == LAST_IDX_C) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = LOAD;
                    index_nxt_s = index_r + ONE_IDX_C;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, decided from the current state.
    always_comb begin
        s_ready_nxt_s    = (state_nxt_s == LOAD);
        busy_nxt_s       = (state_nxt_s != IDLE);
        wr_en_nxt_s      = 1'b0;
        wr_addr_nxt_s    = wr_addr_r;
        wr_data_nxt_s    = wr_data_r;
        done_nxt_s       = 1'b0;
        sat_flag_nxt_s   = sat_flag_r;
        abort_flag_nxt_s = abort_flag_r;
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    sat_flag_nxt_s   = 1'b0;
                    abort_flag_nxt_s = 1'b0;
                end else begin
                    sat_flag_nxt_s   = sat_flag_r;
                end
            end
            LOAD: begin
                if (abort) begin
                    abort_flag_nxt_s = 1'b1;
                end else if (accept_s) begin
                    wr_en_nxt_s    = 1'b1;
                    wr_addr_nxt_s  = index_r;
                    wr_data_nxt_s  = data_sat_s;
                    sat_flag_nxt_s = sat_flag_r | is_min_s;
                end else begin
                    wr_en_nxt_s    = 1'b0;
                end
            end
            MIRROR: begin
                // wr_data_r still holds the beat just written at index_r.
                if (abort) begin
                    abort_flag_nxt_s = 1'b1;
                end else begin
                    wr_en_nxt_s   = 1'b1;
                    wr_addr_nxt_s = TOP_ADDR_C - index_r;
                    wr_data_nxt_s = wr_data_r;
                end
            end
            DONE: begin
                done_nxt_s = 1'b1;
            end
            default: begin
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready_r    <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= ZERO_IDX_C;
            wr_data_r    <= {COEFF_WIDTH{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            sat_flag_r   <= 1'b0;
            abort_flag_r <= 1'b0;
        end else begin
            s_ready_r    <= s_ready_nxt_s;
            wr_en_r      <= wr_en_nxt_s;
            wr_addr_r    <= wr_addr_nxt_s;
            wr_data_r    <= wr_data_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            sat_flag_r   <= sat_flag_nxt_s;
            abort_flag_r <= abort_flag_nxt_s;
        end
    end

    assign s_ready    = s_ready_r;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign sat_flag   = sat_flag_r;
    assign abort_flag = abort_flag_r;

endmodule

// File: tb/tb_coeff_loader.sv
// Self-checking bench for coeff_loader (default and COEFF_LOADER_SYMMETRIC_EN
// builds). Expected RAM writes are queued as beats are driven and checked as
// the DUT writes them.
module tb_coeff_loader;
    import fir_pkg::*;

    localparam int TAPS = 128;
`ifdef COEFF_LOADER_SYMMETRIC_EN
    localparam int NB        = 64;
    localparam int LAST_ADDR = 64;
`else
    localparam int NB        = 128;
    localparam int LAST_ADDR = 127;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start, abort, s_valid, s_ready;
    logic [15:0] s_data, wr_data;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic        busy, done, sat_flag, abort_flag;

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          first_wr_cyc = 0;
    int          last_wr_cyc = 0;
    int          done_cyc = 0;
    logic [6:0]  last_wr_addr = 7'd0;

    coeff_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .sat_flag   (sat_flag),
        .abort_flag (abort_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_sat(input logic [15:0] d);
        return (d === COEFF_MIN) ? COEFF_SAT : d;
    endfunction

    function automatic logic [15:0] gen(input int kind, input int k);
        logic [15:0] d;
        case (kind)
            0: d = 16'(k + 1);
            1: d = 16'($urandom);
            default: begin
                case (k)
                    5:       d = COEFF_MIN;
                    6:       d = COEFF_SAT;
                    7:       d = 16'h7FFF;
                    default: d = 16'(k * 3);
                endcase
            end
        endcase
        return d;
    endfunction

    // Write monitor / scoreboard checker, sampling on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (wr_en) begin
                wr_cnt++;
                if (wr_cnt == 1) first_wr_cyc = cyc;
                last_wr_cyc  = cyc;
                last_wr_addr = wr_addr;
                chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                    chk("wr_data", 32'(wr_data), 32'(mon_e.data));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_cnt();
        wr_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_s_ready"},    32'(s_ready),    32'd0);
        chk({tag, "_wr_en"},      32'(wr_en),      32'd0);
        chk({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
        chk({tag, "_wr_data"},    32'(wr_data),    32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_sat_flag"},   32'(sat_flag),   32'd0);
        chk({tag, "_abort_flag"}, 32'(abort_flag), 32'd0);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_start_ready"}, 32'(s_ready),    32'd1);
        chk({tag, "_start_busy"},  32'(busy),       32'd1);
        chk({tag, "_start_sat"},   32'(sat_flag),   32'd0);
        chk({tag, "_start_abort"}, 32'(abort_flag), 32'd0);
    endtask

    // Drive beats first..n-1; a beat is pushed when the bench expects it accepted.
    task automatic send_beats(input int first, input int n, input int kind, input bit gaps);
        int          k = first;
        int          guard = 0;
        bit          prev_acc = 1'b0;
        bit          v, exp_rdy, acc;
        logic [15:0] d;
        exp_t        e;
        while (k < n && guard < 4000) begin
            guard++;
`ifdef COEFF_LOADER_SYMMETRIC_EN
            exp_rdy = !prev_acc;
`else
            exp_rdy = 1'b1;
`endif
            chk("s_ready_load", 32'(s_ready), 32'(exp_rdy));
            v   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            d   = gen(kind, k);
            acc = v && exp_rdy;
            s_valid = v;
            s_data  = d;
            if (acc) begin
                e.addr = 7'(k);
                e.data = model_sat(d);
                exp_q.push_back(e);
`ifdef COEFF_LOADER_SYMMETRIC_EN
                e.addr = 7'(TAPS - 1 - k);
                exp_q.push_back(e);
`endif
                k++;
            end
            prev_acc = acc;
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (guard >= 4000) chk("beat_timeout", 32'(k), 32'(n));
    endtask

    task automatic finish_load(input string tag);
        repeat (4) @(negedge clk);
        chk({tag, "_done_once"},  32'(done_cnt),                 32'd1);
        chk({tag, "_done_lat"},   32'(done_cyc - last_wr_cyc),   32'd1);
        chk({tag, "_last_addr"},  32'(last_wr_addr),             32'(LAST_ADDR));
        chk({tag, "_wr_count"},   32'(wr_cnt),                   32'(TAPS));
        chk({tag, "_sb_empty"},   32'(exp_q.size()),             32'd0);
        chk({tag, "_busy_idle"},  32'(busy),                     32'd0);
    endtask

    initial begin
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = 16'h0000;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_check("rst");
        rst_n = 1'b1;
        @(negedge clk);
        reset_check("idle");

        // 1: full load, s_valid held high
        clear_cnt();
        do_start("t1");
        send_beats(0, NB, 0, 1'b0);
        finish_load("t1");
        chk("t1_consecutive", 32'(last_wr_cyc - first_wr_cyc), 32'd127);
        chk("t1_sat_clear", 32'(sat_flag), 32'd0);

        // 2: random gaps on s_valid
        clear_cnt();
        do_start("t2");
        send_beats(0, NB, 1, 1'b1);
        finish_load("t2");

        // 3: saturation of beat 5, neighbours pass unchanged
        clear_cnt();
        do_start("t3");
        send_beats(0, NB, 2, 1'b0);
        finish_load("t3");
        chk("t3_sat_flag", 32'(sat_flag), 32'd1);

        // s_valid outside LOAD is ignored
        s_valid = 1'b1;
        s_data  = 16'h5555;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        chk("idle_no_write", 32'(wr_cnt), 32'(TAPS));
        chk("idle_ready", 32'(s_ready), 32'd0);
        chk("t3_sat_sticky", 32'(sat_flag), 32'd1);

        // 4: start while busy ignored, then abort after beat 40
        clear_cnt();
        do_start("t4");
        send_beats(0, 20, 0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_busy_start_ign", 32'(busy), 32'd1);
        send_beats(20, 41, 0, 1'b0);
`ifdef COEFF_LOADER_SYMMETRIC_EN
        @(negedge clk);
`endif
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        @(negedge clk);
        abort   = 1'b0;
        s_valid = 1'b0;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_abort_flag", 32'(abort_flag), 32'd1);
        chk("t4_ready", 32'(s_ready), 32'd0);
        repeat (5) @(negedge clk);
        chk("t4_no_done", 32'(done_cnt), 32'd0);
`ifdef COEFF_LOADER_SYMMETRIC_EN
        chk("t4_wr_count", 32'(wr_cnt), 32'd82);
`else
        chk("t4_wr_count", 32'(wr_cnt), 32'd41);
`endif
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
        // abort and start together in IDLE: abort wins
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("t4_both_busy", 32'(busy), 32'd0);
        chk("t4_both_flag", 32'(abort_flag), 32'd1);

        // 5: restart clears abort_flag, reset mid-load at beat 60, reload
        clear_cnt();
        do_start("t5");
        send_beats(0, 60, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1 reset_check("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        clear_cnt();
        do_start("t5r");
        send_beats(0, NB, 0, 1'b0);
        finish_load("t5r");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
